nibble_serial_adder_ctrl: RTL and testbench

- Sequences one `ripple_carry_adder_4bit` instance (ports `a`, `b`, `cin`, `sum`, `cout`) over WIDTH-bit operands, one nibble per clock, least-significant nibble first.
- The carry is registered between nibbles.
- Supports add and subtract (two's complement).
- Uses a start/busy/done handshake so a wide add can share the single 4-bit datapath in area-constrained designs.

---
 rtl/nibble_serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract engine: one 4-bit ripple adder is stepped over a WIDTH-bit
// operand pair, LS nibble first, with the carry registered between steps.

module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

// Handshake: start is accepted on a rising edge whenever busy=0 (IDLE or DONE);
// busy is high for NIB cycles, then done pulses for one cycle with sum/cout/ovf valid.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic             sign_a, sign_b;
    logic [CW-1:0]    cnt;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             accept;
    logic             last_step;

    ripple_carry_adder_4bit u_add (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CW'(NIB - 1));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1, so the inversion happens once at capture.
            a_sr   <= a;
            b_sr   <= op_sub ? ~b : b;
            carry  <= op_sub ? 1'b1 : cin;
            sign_a <= a[WIDTH-1];
            sign_b <= op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 4;
            b_sr   <= b_sr >> 4;
            res_sr <= {add_sum, res_sr[WIDTH-1:4]};
            carry  <= add_cout;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
                sum  <= {add_sum, res_sr[WIDTH-1:4]};
                cout <= add_cout;
                ovf  <= (sign_a == sign_b) && (add_sum[3] != sign_a);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboarded bench for nibble_serial_adder_ctrl (WIDTH=16): directed cases, back-to-back,
// async reset abort and a random regression against a whole-word reference model.

module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    logic [W+1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {ovf, cout, sum} computed on the whole word.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   f;
        logic         o;
        ye = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? 1'b1 : c)};
        o  = (x[W-1] == ye[W-1]) && (f[W-1] != x[W-1]);
        return {o, f[W], f[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e[W-1:0]));
                check("cout", 64'(cout), 64'(e[W]));
                check("ovf", 64'(ovf), 64'(e[W+1]));
            end
        end
    end

    // Called at a negedge with busy=0; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input bit hold);
        a      = x;
        b      = y;
        cin    = c;
        op_sub = s;
        start  = 1'b1;
        exp_q.push_back(model(x, y, c, s));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_idx;
        logic [W-1:0] x, y;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with latency / pulse width checks
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        busy_cnt = 0; done_cnt = 0; done_idx = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_idx = i; end
        end
        check("lat_busy_cycles", 64'(busy_cnt), 64'(NIB));
        check("lat_done_cycles", 64'(done_cnt), 64'd1);
        check("lat_done_index", 64'(done_idx), 64'(NIB + 1));
        check("t1_sum_hold", 64'(sum), 64'h5555);

        // Carry wrap and full ripple
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        wait_done();
        check("t2_sum", 64'(sum), 64'h0000);
        check("t2_cout", 64'(cout), 64'd1);
        @(negedge clk);
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
        wait_done();
        check("t3_sum", 64'(sum), 64'h8000);
        check("t3_ovf", 64'(ovf), 64'd1);

        // Subtract: borrow, then signed overflow
        @(negedge clk);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        wait_done();
        check("t4_sum", 64'(sum), 64'hFFFE);
        check("t4_cout", 64'(cout), 64'd0);
        @(negedge clk);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        wait_done();
        check("t5_sum", 64'(sum), 64'h7FFF);
        check("t5_cout", 64'(cout), 64'd1);
        check("t5_ovf", 64'(ovf), 64'd1);

        // Start held high: garbage operands while busy, new op taken in the DONE cycle
        @(negedge clk);
        issue(16'h0F0F, 16'h1111, 1'b1, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); cin = 1'($urandom);
        end
        check("b2b_first_done", 64'(done), 64'd1);
        issue(16'hABCD, 16'h1234, 1'b0, 1'b1, 0);
        check("b2b_busy_after_done", 64'(busy), 64'd1);
        wait_done();
        check("b2b_second_sum", 64'(sum), 64'h9999);

        // Async reset in the second RUN cycle aborts the op
        @(negedge clk);
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_sum", 64'(sum), 64'd0);
        check("arst_cout", 64'(cout), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        wait_done();
        check("post_rst_sum", 64'(sum), 64'h0100);

        // Random regression, mixing back-to-back and gapped issues
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            x = W'($urandom);
            y = W'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            issue(x, y, 1'($urandom), 1'($urandom), 0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
